// File: rtl/matrix_inverse_seq.sv
// rtl/matrix_inverse_seq.sv - sequential fraction-free Gauss-Jordan inverter over an N x 2N augmented array
module matrix_inverse_seq #(
    parameter int N = 5,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         start,
    output logic         busy,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         done,
    output logic         singular
);

    localparam int RW  = $clog2(N);
    localparam int RW1 = RW + 1;
    localparam int CW  = $clog2(2 * N);
    localparam int OW  = $clog2(N + 1);
    localparam int LW  = $clog2(N * N + 1);

    localparam logic [LW-1:0] LD_TOTAL  = LW'(N * N);
    localparam logic [RW-1:0] LAST_ROW  = RW'(N - 1);
    localparam logic [CW-1:0] LAST_COL  = CW'(2 * N - 1);
    localparam logic [OW-1:0] LAST_OCOL = OW'(N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEARCH,
        S_SWAP,
        S_LATCH,
        S_UPDATE,
        S_OUTPUT,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [W-1:0]  m [N][2*N];
    logic          ld_enable;
    logic [LW-1:0] ld_cnt;
    logic [RW-1:0] ld_row;
    logic [RW-1:0] ld_col;
    logic [RW-1:0] k;
    logic [RW-1:0] srch_row;
    logic [RW-1:0] sel_row;
    logic [RW-1:0] elim_row;
    logic [CW-1:0] col;
    logic [RW-1:0] out_row;
    logic [OW-1:0] out_col;
    logic [W-1:0]  p_q;
    logic [W-1:0]  f_q;
    logic          singular_q;

    logic          load_full;
    logic          ld_fire;
    logic          start_fire;
    logic          pivot_nz;
    logic [RW-1:0] first_row;
    logic [RW1-1:0] elim_inc;
    logic          elim_last;
    logic          out_fire;
    logic          out_end;
    logic [W-1:0]  out_word;

    always_comb begin
        load_full  = (ld_cnt == LD_TOTAL);
        in_ready   = ld_enable && (state == S_IDLE) && !load_full;
        ld_fire    = in_valid && in_ready;
        start_fire = start && (state == S_IDLE) && load_full;
        pivot_nz   = (m[srch_row][CW'(k)] != '0);
        first_row  = (k == '0) ? RW'(1) : '0;
        // Next row to eliminate, stepping over the pivot row itself
        elim_inc = {1'b0, elim_row} + RW1'(1);
        if (elim_inc == {1'b0, k}) begin
            elim_inc = elim_inc + RW1'(1);
        end
        elim_last = (elim_inc > RW1'(N - 1));
        out_fire  = (state == S_OUTPUT) && out_ready;
        out_end   = (out_row == LAST_ROW) && (out_col == LAST_OCOL);
        if (out_col == '0) begin
            out_word = m[out_row][CW'(out_row)];
        end else begin
            out_word = m[out_row][CW'(N - 1) + CW'(out_col)];
        end
    end

    always_comb begin
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        out_valid = (state == S_OUTPUT);
        out_data  = out_valid ? out_word : '0;
        out_last  = out_valid && out_end;
        singular  = singular_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_fire) begin
                    state_nxt = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (pivot_nz) begin
                    state_nxt = (srch_row == k) ? S_LATCH : S_SWAP;
                end else if (srch_row == LAST_ROW) begin
                    state_nxt = S_DONE;
                end
            end
            S_SWAP:  state_nxt = S_LATCH;
            S_LATCH: state_nxt = S_UPDATE;
            S_UPDATE: begin
                if (col == LAST_COL) begin
                    if (!elim_last) begin
                        state_nxt = S_LATCH;
                    end else if (k == LAST_ROW) begin
                        state_nxt = S_OUTPUT;
                    end else begin
                        state_nxt = S_SEARCH;
                    end
                end
            end
            S_OUTPUT: begin
                if (out_fire && out_end) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_enable  <= 1'b0;
            ld_cnt     <= '0;
            ld_row     <= '0;
            ld_col     <= '0;
            k          <= '0;
            srch_row   <= '0;
            sel_row    <= '0;
            elim_row   <= '0;
            col        <= '0;
            out_row    <= '0;
            out_col    <= '0;
            p_q        <= '0;
            f_q        <= '0;
            singular_q <= 1'b0;
        end else begin
            ld_enable <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (ld_fire) begin
                        ld_cnt <= ld_cnt + LW'(1);
                        if (ld_col == LAST_ROW) begin
                            ld_col <= '0;
                            ld_row <= ld_row + RW'(1);
                        end else begin
                            ld_col <= ld_col + RW'(1);
                        end
                    end
                    if (start_fire) begin
                        k          <= '0;
                        srch_row   <= '0;
                        singular_q <= 1'b0;
                    end
                end
                S_SEARCH: begin
                    if (pivot_nz) begin
                        sel_row  <= srch_row;
                        elim_row <= first_row;
                        col      <= '0;
                    end else if (srch_row == LAST_ROW) begin
                        singular_q <= 1'b1;
                    end else begin
                        srch_row <= srch_row + RW'(1);
                    end
                end
                S_LATCH: begin
                    p_q <= m[k][CW'(k)];
                    f_q <= m[elim_row][CW'(k)];
                end
                S_UPDATE: begin
                    if (col == LAST_COL) begin
                        col <= '0;
                        if (!elim_last) begin
                            elim_row <= elim_inc[RW-1:0];
                        end else if (k != LAST_ROW) begin
                            k        <= k + RW'(1);
                            srch_row <= k + RW'(1);
                        end else begin
                            out_row <= '0;
                            out_col <= '0;
                        end
                    end else begin
                        col <= col + CW'(1);
                    end
                end
                S_OUTPUT: begin
                    if (out_fire) begin
                        if (out_col == LAST_OCOL) begin
                            out_col <= '0;
                            out_row <= out_row + RW'(1);
                        end else begin
                            out_col <= out_col + OW'(1);
                        end
                    end
                end
                S_DONE: begin
                    ld_cnt <= '0;
                    ld_row <= '0;
                    ld_col <= '0;
                end
                default: ;
            endcase
        end
    end

    // Array holds no reset: its contents are only meaningful after a full load
    always_ff @(posedge clk) begin
        if (ld_fire) begin
            m[ld_row][CW'(ld_col)] <= in_data;
            if (ld_cnt == '0) begin
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < N; j++) begin
                        m[i][N + j] <= (i == j) ? W'(1) : '0;
                    end
                end
            end
        end
        if (state == S_SWAP) begin
            for (int c = 0; c < 2 * N; c++) begin
                m[k][c]       <= m[sel_row][c];
                m[sel_row][c] <= m[k][c];
            end
        end
        if (state == S_UPDATE) begin
            m[elim_row][col] <= p_q * m[elim_row][col] - f_q * m[k][col];
        end
    end

endmodule

// File: tb/tb_matrix_inverse_seq.sv
// tb/tb_matrix_inverse_seq.sv - randomized self-checking bench for matrix_inverse_seq (N=2 and N=5 instances)
module tb_matrix_inverse_seq;

    logic        clk;
    logic        rst_n;
    logic        iv   [2];
    logic        ir   [2];
    logic [31:0] id   [2];
    logic        st   [2];
    logic        bz   [2];
    logic        ov   [2];
    logic        ord  [2];
    logic [31:0] od   [2];
    logic        ol   [2];
    logic        dn   [2];
    logic        sg   [2];

    int n_checks = 0;
    int n_fail   = 0;
    int mat [8][8];
    int exp_q [$];
    bit exp_sing;
    int cur = -1;

    bit          stall_p [2];
    logic [31:0] data_p  [2];
    logic        last_p  [2];
    int          e_word;

    matrix_inverse_seq #(.N(2), .W(32)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
        .start(st[0]), .busy(bz[0]),
        .out_valid(ov[0]), .out_ready(ord[0]), .out_data(od[0]), .out_last(ol[0]),
        .done(dn[0]), .singular(sg[0])
    );

    matrix_inverse_seq #(.N(5), .W(32)) dut5 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
        .start(st[1]), .busy(bz[1]),
        .out_valid(ov[1]), .out_ready(ord[1]), .out_data(od[1]), .out_last(ol[1]),
        .done(dn[1]), .singular(sg[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, $signed(act), act, $signed(exp), exp);
        end
    endtask

    // Fraction-free Gauss-Jordan on the augmented matrix in plain integer arithmetic
    task automatic build_model(input int n);
        int a [8][16];
        int piv, p, f, t;
        exp_q.delete();
        exp_sing = 1'b0;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < 2 * n; j++)
                a[i][j] = (j < n) ? mat[i][j] : ((j - n == i) ? 1 : 0);
        for (int kk = 0; kk < n; kk++) begin
            piv = -1;
            for (int r = kk; r < n; r++)
                if (piv < 0 && a[r][kk] != 0) piv = r;
            if (piv < 0) begin
                exp_sing = 1'b1;
                return;
            end
            for (int c = 0; c < 2 * n; c++) begin
                t = a[kk][c]; a[kk][c] = a[piv][c]; a[piv][c] = t;
            end
            for (int r = 0; r < n; r++) begin
                if (r != kk) begin
                    p = a[kk][kk];
                    f = a[r][kk];
                    for (int c = 0; c < 2 * n; c++) a[r][c] = p * a[r][c] - f * a[kk][c];
                end
            end
        end
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(a[i][i]);
            for (int j = 0; j < n; j++) exp_q.push_back(a[i][n + j]);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                stall_p[d] = 1'b0;
            end else begin
                if (stall_p[d]) begin
                    check("stall_valid", {31'd0, ov[d]}, 32'd1);
                    check("stall_data", od[d], data_p[d]);
                    check("stall_last", {31'd0, ol[d]}, {31'd0, last_p[d]});
                end
                if (ov[d] && ord[d]) begin
                    if (d != cur || exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL out_unexpected: dut%0d offered %0d, expected no word", d, $signed(od[d]));
                    end else begin
                        e_word = exp_q.pop_front();
                        check("out_data", od[d], e_word);
                        check("out_last", {31'd0, ol[d]}, (exp_q.size() == 0) ? 32'd1 : 32'd0);
                    end
                end
                stall_p[d] = ov[d] && !ord[d];
                data_p[d]  = od[d];
                last_p[d]  = ol[d];
            end
        end
    end

    task automatic load_word(input int d, input int v);
        int cyc = 0;
        iv[d] = 1'b1;
        id[d] = v;
        while (!ir[d] && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("in_ready_wait", {31'd0, ir[d]}, 32'd1);
        @(posedge clk); #1;
        iv[d] = 1'b0;
    endtask

    // mode: 0 = out_ready always high, 1 = toggled each cycle, 2 = random
    task automatic run_case(input int d, input int n, input int first, input int mode, input bit extra);
        int cyc = 0;
        for (int i = first; i < n * n; i++) load_word(d, mat[i / n][i % n]);
        build_model(n);
        cur = d;
        st[d] = 1'b1;
        @(posedge clk); #1;
        st[d] = 1'b0;
        check("busy_after_start", {31'd0, bz[d]}, 32'd1);
        check("singular_cleared", {31'd0, sg[d]}, 32'd0);
        while (!dn[d] && cyc < 4000) begin
            st[d]  = extra && (cyc == 3);
            ord[d] = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            cyc++;
        end
        st[d]  = 1'b0;
        ord[d] = 1'b1;
        check("done_seen", {31'd0, dn[d]}, 32'd1);
        check("singular", {31'd0, sg[d]}, {31'd0, exp_sing});
        check("words_left", exp_q.size(), 32'd0);
        check("busy_in_done", {31'd0, bz[d]}, 32'd1);
        @(posedge clk); #1;
        check("done_one_cycle", {31'd0, dn[d]}, 32'd0);
        check("busy_idle", {31'd0, bz[d]}, 32'd0);
        check("in_ready_reload", {31'd0, ir[d]}, 32'd1);
        check("singular_hold", {31'd0, sg[d]}, {31'd0, exp_sing});
    endtask

    task automatic check_reset_outputs(input int d);
        check("rst_in_ready", {31'd0, ir[d]}, 32'd0);
        check("rst_busy", {31'd0, bz[d]}, 32'd0);
        check("rst_out_valid", {31'd0, ov[d]}, 32'd0);
        check("rst_out_last", {31'd0, ol[d]}, 32'd0);
        check("rst_out_data", od[d], 32'd0);
        check("rst_done", {31'd0, dn[d]}, 32'd0);
        check("rst_singular", {31'd0, sg[d]}, 32'd0);
    endtask

    task automatic set2(input int a, input int b, input int c, input int e);
        mat[0][0] = a; mat[0][1] = b; mat[1][0] = c; mat[1][1] = e;
    endtask

    task automatic rand_mat(input int n);
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++) mat[i][j] = int'($urandom_range(0, 8)) - 4;
    endtask

    initial begin
        int pin1 [6];
        int pin2 [6];
        int cyc;
        pin1 = '{2, 2, -2, 1, -1, 2};
        pin2 = '{1, 0, 1, 1, 1, 0};
        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0; id[d] = '0; st[d] = 1'b0; ord[d] = 1'b1;
        end
        rst_n = 1'b0;
        #3;
        check_reset_outputs(0);
        check_reset_outputs(1);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready_rise0", {31'd0, ir[0]}, 32'd1);
        check("in_ready_rise1", {31'd0, ir[1]}, 32'd1);

        set2(2, 1, 1, 1);
        build_model(2);
        for (int i = 0; i < 6; i++) check("model_pin_inv", exp_q[i], pin1[i]);
        set2(0, 1, 1, 0);
        build_model(2);
        for (int i = 0; i < 6; i++) check("model_pin_swap", exp_q[i], pin2[i]);
        set2(1, 2, 2, 4);
        build_model(2);
        check("model_pin_sing", {31'd0, exp_sing}, 32'd1);
        check("model_pin_sing_words", exp_q.size(), 32'd0);
        exp_q.delete();

        set2(2, 1, 1, 1);
        for (int i = 0; i < 3; i++) load_word(0, mat[i / 2][i % 2]);
        st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        check("early_start_ignored", {31'd0, bz[0]}, 32'd0);
        run_case(0, 2, 3, 0, 1'b1);

        set2(0, 1, 1, 0);
        run_case(0, 2, 0, 2, 1'b0);
        set2(1, 2, 2, 4);
        run_case(0, 2, 0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("singular_sticky", {31'd0, sg[0]}, 32'd1);
        set2(2, 1, 1, 1);
        run_case(0, 2, 0, 1, 1'b0);

        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++) mat[i][j] = (i == j) ? 1 : 0;
        run_case(1, 5, 0, 1, 1'b0);

        for (int t = 0; t < 6; t++) begin
            rand_mat(5);
            run_case(1, 5, 0, 2, 1'b0);
        end
        for (int t = 0; t < 6; t++) begin
            rand_mat(2);
            run_case(0, 2, 0, 2, 1'b0);
        end

        rand_mat(5);
        mat[0][0] = 3;
        cur = 1;
        exp_q.delete();
        for (int i = 0; i < 25; i++) load_word(1, mat[i / 5][i % 5]);
        st[1] = 1'b1;
        @(posedge clk); #1;
        st[1] = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs(1);
        check_reset_outputs(0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_midrst", {31'd0, ir[1]}, 32'd1);
        check("no_done_after_midrst", {31'd0, dn[1]}, 32'd0);
        run_case(1, 5, 0, 2, 1'b0);

        cyc = 0;
        while (cyc < 5) begin
            @(posedge clk); #1;
            cyc++;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, expected test completion");
        $fatal(1, "watchdog");
    end

endmodule
